// File: rtl/tr_bus_pkg.sv
// Shared definitions for the tester memory bus: default widths, responder
// FSM states and the error-counter ceiling.
package tr_bus_pkg;

    localparam int TR_ADDR_WIDTH = 20;
    localparam int TR_DATA_WIDTH = 16;
    localparam int TR_DEPTH_LOG2 = 10;
    localparam int TR_WAIT_WIDTH = 4;

    localparam logic [7:0] ERR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } tr_state_e;

endpackage

// File: rtl/tr_ram_bytewise.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port (one cycle latency).
module tr_ram_bytewise #(
    parameter int    DATA_WIDTH = 16,
    parameter int    DEPTH_LOG2 = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic                    clock,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DEPTH_LOG2-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [LANES-1:0]      lane_we;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane_we
            assign lane_we[gi] = we_i & be_i[gi];
        end
    endgenerate

    // Byte-lane writes and registered read (read returns pre-write data)
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_we[i]) begin
                mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tr_bus_responder.sv
// Memory-bus responder: one outstanding access, programmable wait states,
// byte-enabled RAM behind it, saturating protocol/range error counter.
module tr_bus_responder
    import tr_bus_pkg::*;
#(
    parameter int    ADDR_WIDTH = TR_ADDR_WIDTH,
    parameter int    DATA_WIDTH = TR_DATA_WIDTH,
    parameter int    DEPTH_LOG2 = TR_DEPTH_LOG2,
    parameter int    WAIT_WIDTH = TR_WAIT_WIDTH,
    parameter string INIT_FILE  = ""
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WAIT_WIDTH-1:0]   wait_states,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdataready,
    output logic [7:0]              err_count
);

    localparam int LANES = DATA_WIDTH / 8;

    tr_state_e             state_q;
    logic [WAIT_WIDTH-1:0] cnt_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [LANES-1:0]      be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  is_read_q;
    logic                  oor_q;
    logic [DATA_WIDTH-1:0] readdata_q;
    logic                  rdv_q;
    logic [7:0]            err_q;

    logic                  req;
    logic                  oor_in;
    logic [1:0]            err_inc;
    logic [8:0]            err_sum;
    logic [7:0]            err_d;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign req = read | write;

    // Any address bit above the RAM index marks the access out of range
    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_oor
            assign oor_in = |address[ADDR_WIDTH-1:DEPTH_LOG2];
        end else begin : g_no_oor
            assign oor_in = 1'b0;
        end
    endgenerate

    // The RAM reads continuously: the live address while idle, the latched
    // one afterwards, so its registered output is already valid in ACCESS.
    assign ram_addr = (state_q == S_IDLE) ? address[DEPTH_LOG2-1:0] : addr_q;
    assign ram_we   = (state_q == S_ACCESS) && !is_read_q && !oor_q && !reset;

    tr_ram_bytewise #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clock   (clock),
        .we_i    (ram_we),
        .be_i    (be_q),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Error events of this cycle and the saturated next count
    always_comb begin
        err_inc = 2'd0;
        if (state_q == S_IDLE && req) begin
            err_inc = {1'b0, read & write} + {1'b0, oor_in};
        end else if (state_q == S_WAIT && !req) begin
            err_inc = 2'd1;
        end
        err_sum = {1'b0, err_q} + {7'd0, err_inc};
        err_d   = err_sum[8] ? ERR_MAX : err_sum[7:0];
    end

    // Responder FSM with wait counter, request latches and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            is_read_q  <= 1'b0;
            oor_q      <= 1'b0;
            readdata_q <= '0;
            rdv_q      <= 1'b0;
            err_q      <= '0;
        end else begin
            rdv_q <= 1'b0;
            err_q <= err_d;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q    <= address[DEPTH_LOG2-1:0];
                        be_q      <= byteenable;
                        wdata_q   <= writedata;
                        is_read_q <= read;
                        oor_q     <= oor_in;
                        cnt_q     <= wait_states;
                        state_q   <= (wait_states != '0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - WAIT_WIDTH'(1);
                        if (cnt_q == WAIT_WIDTH'(1)) begin
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (is_read_q) begin
                        readdata_q <= oor_q ? '0 : ram_rdata;
                        rdv_q      <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign waitrequest   = reset | (req && (state_q != S_ACCESS));
    assign readdata      = readdata_q;
    assign readdataready = rdv_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_tr_bus_responder.sv
// Directed bench for tr_bus_responder: a cycle-level expectation model
// derived from the access timing rules, checked on every cycle, plus
// literal expectations from hand-worked transactions.
module tb_tr_bus_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  wait_states;
    logic [19:0] address;
    logic [1:0]  byteenable;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic        waitrequest;
    logic [15:0] readdata;
    logic        readdataready;
    logic [7:0]  err_count;

    tr_bus_responder dut (
        .clock         (clock),
        .reset         (reset),
        .wait_states   (wait_states),
        .address       (address),
        .byteenable    (byteenable),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdataready (readdataready),
        .err_count     (err_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model state: memory image, error count, and this cycle's expected outputs
    logic [15:0] mem_model [1024];
    int          err_model;
    bit          chk_en = 1'b0;
    logic        exp_wr;
    logic        exp_rdv;
    logic [15:0] exp_rd;
    logic [7:0]  exp_err;

    int          acc_cycle;
    int          strobe_cycle;
    logic [15:0] strobe_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_waitrequest", {31'd0, waitrequest}, {31'd0, exp_wr});
            check("cyc_readdataready", {31'd0, readdataready}, {31'd0, exp_rdv});
            check("cyc_readdata", {16'd0, readdata}, {16'd0, exp_rd});
            check("cyc_err_count", {24'd0, err_count}, {24'd0, exp_err});
        end
    end

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // One bus cycle: note access/strobe cycle indices mid-cycle, then advance
    task automatic step(input int k);
        @(negedge clock);
        if (waitrequest === 1'b0 && acc_cycle < 0) acc_cycle = k;
        if (readdataready === 1'b1) begin
            strobe_cycle = k;
            strobe_data  = readdata;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            read = 1'b0; write = 1'b0;
            exp_wr = 1'b0; exp_rdv = 1'b0; exp_err = 8'(err_model);
            step(k);
        end
    endtask

    // Complete transfer: request seen at cycle 0, accept at n+1, strobe at n+2
    task automatic xfer(input bit rd, input bit wr, input logic [19:0] addr,
                        input logic [1:0] be, input logic [15:0] wd, input int n);
        bit oor;
        int e_after;
        oor = (addr >= 20'd1024);
        e_after = sat(err_model + int'(rd & wr) + int'(oor));
        acc_cycle = -1;
        strobe_cycle = -1;
        for (int k = 0; k <= n + 1; k++) begin
            read = rd; write = wr; address = addr; byteenable = be; writedata = wd;
            wait_states = (k == 0) ? 4'(n) : 4'($urandom);
            exp_wr  = (k != n + 1);
            exp_rdv = 1'b0;
            exp_err = (k == 0) ? 8'(err_model) : 8'(e_after);
            step(k);
        end
        err_model = e_after;
        read = 1'b0; write = 1'b0;
        if (!rd && wr && !oor) begin
            for (int l = 0; l < 2; l++)
                if (be[l]) mem_model[addr[9:0]][l*8 +: 8] = wd[l*8 +: 8];
        end
        if (rd) begin
            exp_wr = 1'b0; exp_rdv = 1'b1; exp_err = 8'(err_model);
            exp_rd = oor ? 16'h0000 : mem_model[addr[9:0]];
            step(n + 2);
        end
        $display("XFER %s addr=%05h be=%b wd=%04h ws=%0d acc=%0d strobe=%0d rd=%04h err=%0d",
                 rd ? "RD" : "WR", addr, be, wd, n, acc_cycle, strobe_cycle, strobe_data, err_model);
    endtask

    // Read request that is withdrawn at cycle d while still waiting
    task automatic abort_read(input logic [19:0] addr, input int n, input int d);
        for (int k = 0; k < d; k++) begin
            read = 1'b1; write = 1'b0; address = addr; wait_states = 4'(n);
            exp_wr = 1'b1; exp_rdv = 1'b0; exp_err = 8'(err_model);
            step(k);
        end
        read = 1'b0;
        exp_wr = 1'b0; exp_err = 8'(err_model);
        step(d);
        err_model = sat(err_model + 1);
        $display("ABORT addr=%05h ws=%0d drop=%0d err=%0d", addr, n, d, err_model);
    endtask

    // Write request interrupted by reset at cycle d while waiting
    task automatic reset_mid_write(input logic [19:0] addr, input logic [15:0] wd, input int n, input int d);
        strobe_cycle = -1;
        acc_cycle = -1;
        for (int k = 0; k < d; k++) begin
            write = 1'b1; read = 1'b0; address = addr; byteenable = 2'b11;
            writedata = wd; wait_states = 4'(n);
            exp_wr = 1'b1; exp_rdv = 1'b0; exp_err = 8'(err_model);
            step(k);
        end
        reset = 1'b1; write = 1'b0;
        exp_wr = 1'b1; exp_rdv = 1'b0; exp_err = 8'(err_model);
        step(d);
        reset = 1'b0;
        err_model = 0; exp_rd = 16'h0000;
        exp_wr = 1'b0; exp_err = 8'd0;
        step(d + 1);
        $display("RESET_MID addr=%05h wd=%04h ws=%0d at=%0d", addr, wd, n, d);
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0;
        byteenable = '0; writedata = '0; wait_states = '0;
        err_model = 0;
        @(posedge clock);
        #1;
        exp_wr = 1'b1; exp_rdv = 1'b0; exp_rd = 16'h0000; exp_err = 8'd0;
        chk_en = 1'b1;
        step(0);
        check("reset_waitrequest", {31'd0, waitrequest}, 32'd1);
        check("reset_err", {24'd0, err_count}, 32'd0);
        reset = 1'b0;
        idle_cycles(2);

        // Known RAM image
        for (int a = 0; a < 1024; a++) begin
            xfer(1'b0, 1'b1, 20'(a), 2'b11, 16'h0000, 0);
            mem_model[a] = 16'h0000;
        end

        // Zero-wait write and read-back
        xfer(1'b0, 1'b1, 20'h00010, 2'b11, 16'hA5C3, 0);
        check("ws0_write_accept_cycle", 32'(acc_cycle), 32'd1);
        xfer(1'b1, 1'b0, 20'h00010, 2'b00, 16'h0000, 0);
        check("ws0_read_strobe_cycle", 32'(strobe_cycle), 32'd2);
        check("ws0_read_data", {16'd0, strobe_data}, 32'h0000A5C3);

        // Byte lanes
        xfer(1'b0, 1'b1, 20'h00020, 2'b11, 16'h1234, 0);
        xfer(1'b0, 1'b1, 20'h00020, 2'b01, 16'hFFFF, 1);
        xfer(1'b1, 1'b0, 20'h00020, 2'b00, 16'h0000, 0);
        check("lane_lo_data", {16'd0, strobe_data}, 32'h000012FF);
        xfer(1'b0, 1'b1, 20'h00020, 2'b10, 16'h0000, 2);
        xfer(1'b1, 1'b0, 20'h00020, 2'b01, 16'h0000, 0);
        check("lane_hi_data", {16'd0, strobe_data}, 32'h000000FF);
        xfer(1'b0, 1'b1, 20'h00020, 2'b00, 16'hAAAA, 0);
        xfer(1'b1, 1'b0, 20'h00020, 2'b11, 16'h0000, 0);
        check("be0_unchanged", {16'd0, strobe_data}, 32'h000000FF);
        check("be0_no_error", {24'd0, err_count}, 32'd0);

        // Five wait states
        xfer(1'b1, 1'b0, 20'h00010, 2'b11, 16'h0000, 5);
        check("ws5_accept_cycle", 32'(acc_cycle), 32'd6);
        check("ws5_strobe_cycle", 32'(strobe_cycle), 32'd7);
        check("ws5_data", {16'd0, strobe_data}, 32'h0000A5C3);

        // Error cases
        xfer(1'b1, 1'b0, 20'h00400, 2'b11, 16'h0000, 0);
        check("oor_read_data", {16'd0, strobe_data}, 32'h00000000);
        check("oor_read_err", {24'd0, err_count}, 32'd1);
        xfer(1'b1, 1'b1, 20'h00010, 2'b11, 16'hBEEF, 1);
        check("rw_both_is_read", {16'd0, strobe_data}, 32'h0000A5C3);
        check("rw_both_err", {24'd0, err_count}, 32'd2);
        abort_read(20'h00010, 4, 2);
        idle_cycles(1);
        check("abort_err", {24'd0, err_count}, 32'd3);
        xfer(1'b0, 1'b1, 20'h00410, 2'b11, 16'h1111, 0);
        xfer(1'b1, 1'b0, 20'h00010, 2'b11, 16'h0000, 0);
        check("oor_write_discarded", {16'd0, strobe_data}, 32'h0000A5C3);
        check("oor_write_err", {24'd0, err_count}, 32'd4);

        // Saturation: each read+write out of range counts twice
        for (int i = 0; i < 130; i++) begin
            xfer(1'b1, 1'b1, 20'h00400 + 20'(i), 2'b11, 16'h0000, 0);
        end
        check("err_saturated", {24'd0, err_count}, 32'd255);

        // Reset while a write waits
        reset_mid_write(20'h00005, 16'hDEAD, 5, 3);
        check("rst_no_strobe", 32'(strobe_cycle), 32'hFFFFFFFF);
        check("rst_err_cleared", {24'd0, err_count}, 32'd0);
        xfer(1'b1, 1'b0, 20'h00005, 2'b11, 16'h0000, 0);
        check("rst_write_dropped", {16'd0, strobe_data}, 32'h00000000);

        // Random back-to-back write/read pairs
        for (int i = 0; i < 256; i++) begin
            xfer(1'b0, 1'b1, 20'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                 16'($urandom), $urandom_range(0, 3));
            xfer(1'b1, 1'b0, 20'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                 16'h0000, $urandom_range(0, 3));
        end
        check("random_err_zero", {24'd0, err_count}, 32'd0);

        idle_cycles(2);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
